// File: rtl/mac_accumulator_8bit.sv
// rtl/mac_accumulator_8bit.sv - streaming 8x8 multiply-accumulate with framed result handshake
module mac_accumulator_8bit #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic             op_last;
    logic             s1_valid;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [15:0]      prod;
    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] cnt_inc;
    logic             accept;

    assign accept  = in_valid && in_ready;
    assign prod    = {8'b0, op_a} * {8'b0, op_b};
    assign sum     = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, prod};
    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_next = DRAIN;
            end
            DRAIN: state_next = OUT;
            OUT:   if (out_valid && out_ready) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            op_last  <= 1'b0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                op_a    <= in_a;
                op_b    <= in_b;
                op_last <= in_last;
            end
        end
    end

    // The last beat both publishes the frame and clears the running state on one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_acc   <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (s1_valid) begin
                if (op_last) begin
                    out_acc   <= sum[ACC_W-1:0];
                    out_ovf   <= ovf | sum[ACC_W];
                    out_cnt   <= cnt_inc;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    ovf       <= 1'b0;
                    cnt       <= '0;
                end else begin
                    acc <= sum[ACC_W-1:0];
                    ovf <= ovf | sum[ACC_W];
                    cnt <= cnt_inc;
                end
            end
        end
    end

endmodule
